acia_uart: RTL

- 6850-style serial port peripheral on the Z80 I/O bus inside the system; it directly consumes the top-level RX pin and drives TX.
- Two register addresses: status/control and data.
- Single-byte transmit holding register and single-byte receive holding register.
- Fixed framing 8N1, with a maskable interrupt to the CPU.
- Exposes an rx-busy diag line for the top-level diag header.

---
 rtl/acia_pkg.sv | 35 +++
 rtl/acia_rx.sv | 124 ++++++++++++
 rtl/acia_uart.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/acia_pkg.sv
// ============================================================================
// Module   : acia_pkg
// Brief    : Register bit map, control codes and FSM encodings for acia_uart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package acia_pkg;

    localparam int c_bit_rdrf = 0;
    localparam int c_bit_tdre = 1;
    localparam int c_bit_fe   = 4;
    localparam int c_bit_ovrn = 5;
    localparam int c_bit_irq  = 7;

    localparam logic [1:0] c_mreset_code = 2'b11;
    localparam logic [1:0] c_tie_code    = 2'b01;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/acia_rx.sv
// ============================================================================
// Module   : acia_rx
// Brief    : 8N1 receiver: rx synchroniser, mid-bit sampling FSM, byte strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acia_rx
    import acia_pkg::*;
#(
    parameter int BIT_DIV = 139
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] c_full = 16'(BIT_DIV - 1);
    localparam logic [15:0] c_half = 16'(BIT_DIV / 2 - 1);

    logic [1:0]  r_sync;
    logic        r_rx_prev;
    rx_state_t   r_state;
    rx_state_t   w_state_n;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_n;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_n;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_n;
    logic        w_rxs;
    logic        w_fall;
    logic        w_expire;

    assign w_rxs    = r_sync[1];
    assign w_fall   = r_rx_prev & ~w_rxs;
    assign w_expire = (r_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state <= RX_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
        end
    end

    // Counter is loaded with (period - 1) so a state lasts exactly one period.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_bit_n    = r_bit;
        w_shift_n  = r_shift;
        byte_valid = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_state_n = RX_START;
                    w_cnt_n   = c_half;
                end
            end
            RX_START: begin
                if (!w_expire) begin
                    w_cnt_n = r_cnt - 16'd1;
                end else if (!w_rxs) begin
                    w_state_n = RX_DATA;
                    w_cnt_n   = c_full;
                    w_bit_n   = 3'd0;
                end else begin
                    w_state_n = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (!w_expire) begin
                    w_cnt_n = r_cnt - 16'd1;
                end else begin
                    w_shift_n = {w_rxs, r_shift[7:1]};
                    w_cnt_n   = c_full;
                    if (r_bit == 3'd7) begin
                        w_state_n = RX_STOP;
                    end else begin
                        w_bit_n = r_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (!w_expire) begin
                    w_cnt_n = r_cnt - 16'd1;
                end else begin
                    byte_valid = 1'b1;
                    w_state_n  = RX_IDLE;
                end
            end
            default: w_state_n = RX_IDLE;
        endcase
    end

    assign byte_data = r_shift;
    assign frame_err = ~w_rxs;
    assign busy      = (r_state != RX_IDLE);

endmodule

`default_nettype wire

// File: rtl/acia_uart.sv
// ============================================================================
// Module   : acia_uart
// Brief    : 6850-style ACIA: status/control and data registers, 8N1 TX/RX, irq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acia_uart
    import acia_pkg::*;
#(
    parameter int BIT_DIV = 139
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic       rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rx,
    output logic       tx,
    output logic       irq,
    output logic       acia_diag
);

    localparam logic [15:0] c_full = 16'(BIT_DIV - 1);

    logic        r_cs_prev;
    logic        w_strobe;
    logic        w_ctrl_wr;
    logic        w_mreset;
    logic        w_data_rd;
    logic        w_data_wr;

    logic [7:0]  r_rdr;
    logic [7:0]  r_tdr;
    logic        r_rdrf;
    logic        r_tdre;
    logic        r_fe;
    logic        r_ovrn;
    logic        r_rie;
    logic        r_tie;
    logic        r_irq;
    logic [7:0]  w_status;

    logic        w_rx_valid;
    logic [7:0]  w_rx_byte;
    logic        w_rx_ferr;
    logic        w_rdrf_kept;
    logic        w_fe_kept;
    logic        w_ovrn_kept;

    tx_state_t   r_tx_state;
    tx_state_t   w_tx_state_n;
    logic [15:0] r_tx_cnt;
    logic [15:0] w_tx_cnt_n;
    logic [2:0]  r_tx_bit;
    logic [2:0]  w_tx_bit_n;
    logic [7:0]  r_tx_shift;
    logic [7:0]  w_tx_shift_n;
    logic        r_tx;
    logic        w_tx_n;
    logic        w_tx_load;
    logic        w_tx_expire;

    // Bus side effects fire once per access, on the first cycle of cs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_prev <= 1'b0;
        end else begin
            r_cs_prev <= cs;
        end
    end

    assign w_strobe  = cs & ~r_cs_prev;
    assign w_ctrl_wr = w_strobe & we & ~rs;
    assign w_mreset  = w_ctrl_wr & (din[1:0] == c_mreset_code);
    assign w_data_rd = w_strobe & ~we & rs;
    assign w_data_wr = w_strobe & we & rs;

    acia_rx #(
        .BIT_DIV (BIT_DIV)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_mreset),
        .rx         (rx),
        .byte_valid (w_rx_valid),
        .byte_data  (w_rx_byte),
        .frame_err  (w_rx_ferr),
        .busy       (acia_diag)
    );

    // A data read in the same cycle as delivery clears first, then the byte loads.
    assign w_rdrf_kept = r_rdrf & ~w_data_rd;
    assign w_fe_kept   = r_fe   & ~w_data_rd;
    assign w_ovrn_kept = r_ovrn & ~w_data_rd;

    always_ff @(posedge clk) begin
        if (reset || w_mreset) begin
            r_rdr  <= 8'd0;
            r_tdr  <= 8'd0;
            r_rdrf <= 1'b0;
            r_tdre <= 1'b1;
            r_fe   <= 1'b0;
            r_ovrn <= 1'b0;
            r_rie  <= 1'b0;
            r_tie  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_rie <= din[7];
                r_tie <= (din[6:5] == c_tie_code);
            end
            if (w_data_wr) begin
                r_tdr  <= din;
                r_tdre <= 1'b0;
            end else if (w_tx_load) begin
                r_tdre <= 1'b1;
            end
            if (w_rx_valid && !w_rdrf_kept) begin
                r_rdr  <= w_rx_byte;
                r_rdrf <= 1'b1;
                r_fe   <= w_rx_ferr;
                r_ovrn <= w_ovrn_kept;
            end else if (w_rx_valid) begin
                r_fe   <= w_fe_kept | w_rx_ferr;
                r_ovrn <= 1'b1;
            end else begin
                r_rdrf <= w_rdrf_kept;
                r_fe   <= w_fe_kept;
                r_ovrn <= w_ovrn_kept;
            end
            r_irq <= (r_rie & (r_rdrf | r_ovrn)) | (r_tie & r_tdre);
        end
    end

    always_comb begin
        w_status             = 8'd0;
        w_status[c_bit_rdrf] = r_rdrf;
        w_status[c_bit_tdre] = r_tdre;
        w_status[c_bit_fe]   = r_fe;
        w_status[c_bit_ovrn] = r_ovrn;
        w_status[c_bit_irq]  = r_irq;
    end

    assign dout = rs ? r_rdr : w_status;
    assign irq  = r_irq;
    assign tx   = r_tx;

    always_ff @(posedge clk) begin
        if (reset || w_mreset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx       <= w_tx_n;
        end
    end

    assign w_tx_expire = (r_tx_cnt == 16'd0);

    // The line level is registered from the next state, so each state spans BIT_DIV clks.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_n       = r_tx;
        w_tx_load    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_n = 1'b1;
                if (!r_tdre) begin
                    w_tx_load    = 1'b1;
                    w_tx_shift_n = r_tdr;
                    w_tx_state_n = TX_START;
                    w_tx_cnt_n   = c_full;
                    w_tx_n       = 1'b0;
                end
            end
            TX_START: begin
                if (!w_tx_expire) begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_state_n = TX_DATA;
                    w_tx_cnt_n   = c_full;
                    w_tx_bit_n   = 3'd0;
                    w_tx_n       = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (!w_tx_expire) begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_cnt_n = c_full;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = TX_STOP;
                        w_tx_n       = 1'b1;
                    end else begin
                        w_tx_shift_n = {1'b1, r_tx_shift[7:1]};
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_n       = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (!w_tx_expire) begin
                    w_tx_cnt_n = r_tx_cnt - 16'd1;
                end else if (!r_tdre) begin
                    w_tx_load    = 1'b1;
                    w_tx_shift_n = r_tdr;
                    w_tx_state_n = TX_START;
                    w_tx_cnt_n   = c_full;
                    w_tx_n       = 1'b0;
                end else begin
                    w_tx_state_n = TX_IDLE;
                    w_tx_n       = 1'b1;
                end
            end
            default: begin
                w_tx_state_n = TX_IDLE;
                w_tx_n       = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire
